// File: rtl/division.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/calculated handshake.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start          request, sampled only in IDLE
//   a, b           dividend (2*WIDTH), divisor (WIDTH)
//   q, r           quotient, remainder (held until next accepted start)
//   overflow       quotient does not fit or b == 0
//   busy           high outside IDLE
//   calculated     one-cycle done pulse
module division #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   r,
   output logic               overflow,
   output logic               busy,
   output logic               calculated
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH:0]   p_q;
   logic [WIDTH-1:0] sh_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   t_d;
   logic [WIDTH:0]   p_d;
   logic [WIDTH-1:0] sh_d;
   logic             ge_d;
   logic             last_d;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits.
   always_comb begin
      t_d    = {p_q[WIDTH-1:0], sh_q[WIDTH-1]};
      ge_d   = (t_d >= {1'b0, d_q});
      p_d    = ge_d ? (t_d - {1'b0, d_q}) : t_d;
      sh_d   = {sh_q[WIDTH-2:0], ge_d};
      last_d = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         d_q        <= '0;
         p_q        <= '0;
         sh_q       <= '0;
         cnt_q      <= '0;
         q          <= '0;
         r          <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
         calculated <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  d_q  <= b;
                  p_q  <= {1'b0, a[2*WIDTH-1:WIDTH]};
                  sh_q <= a[WIDTH-1:0];
                  busy <= 1'b1;
                  // High half >= divisor means the quotient cannot fit;
                  // this also catches b == 0.
                  if (a[2*WIDTH-1:WIDTH] >= b) begin
                     state_q    <= DONE;
                     overflow   <= 1'b1;
                     q          <= '1;
                     r          <= '0;
                     calculated <= 1'b1;
                  end else begin
                     state_q  <= RUN;
                     cnt_q    <= '0;
                     overflow <= 1'b0;
                  end
               end
            end
            RUN: begin
               p_q   <= p_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_d) begin
                  state_q    <= DONE;
                  q          <= sh_d;
                  r          <= p_d[WIDTH-1:0];
                  calculated <= 1'b1;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               busy       <= 1'b0;
               calculated <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               busy       <= 1'b0;
               calculated <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_division.sv
// Scoreboard bench for the sequential divider: the driver pushes
// expected results, a negedge monitor pops and compares on calculated.
module tb_division;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2*W-1:0]  a;
   logic [W-1:0]    b;
   logic [W-1:0]    q;
   logic [W-1:0]    r;
   logic            overflow;
   logic            busy;
   logic            calculated;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   division #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .q          (q),
      .r          (r),
      .overflow   (overflow),
      .busy       (busy),
      .calculated (calculated)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)",
                  nm, act, req, $time);
      end
   endtask

   // Monitor: every calculated pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && calculated) begin
         if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL spurious_calculated: got pulse, required none (t=%0t)",
                     $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("r", 32'(r), 32'(e.r));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic eo, input logic push);
      exp_t e;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      e.q   = eq;
      e.r   = er;
      e.ovf = eo;
      e.cyc = cyc + 1 + (eo ? 0 : W);
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      chk("pending_after_wait", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("calc_idle", 32'(calculated), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   c0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_calc", 32'(calculated), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // basic
      issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
      wait_done();

      // multiplier inverse, max operands
      issue(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b1);
      wait_done();

      // divide by zero, quotient overflow
      issue(32'h12345678, 16'h0, 16'hFFFF, 16'h0, 1'b1, 1'b1);
      wait_done();
      issue(32'h00010000, 16'h1, 16'hFFFF, 16'h0, 1'b1, 1'b1);
      wait_done();

      // start during RUN ignored
      issue(32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      a     = 32'd9;
      b     = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // reset mid-RUN: no result expected for this op
      issue(32'd1000, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_q", 32'(q), 32'd0);
      chk("midrst_r", 32'(r), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_calc", 32'(calculated), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 4) @(negedge clk);
      chk("no_pulse_after_rst", 32'(sb.size()), 32'd0);
      issue(32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
      wait_done();

      // back-to-back with start held high
      @(negedge clk);
      a     = 32'h0000FFFF;
      b     = 16'h0010;
      start = 1'b1;
      c0    = cyc + 1;
      e.q   = 16'h0FFF;
      e.r   = 16'h000F;
      e.ovf = 1'b0;
      e.cyc = c0 + W;
      sb.push_back(e);
      e.q   = 16'd4;
      e.r   = 16'd1;
      e.ovf = 1'b0;
      e.cyc = c0 + W + 2 + W;
      sb.push_back(e);
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge clk);
         if (calculated) break;
      end
      chk("b2b_first_calc", 32'(calculated), 32'd1);
      a = 32'd17;
      b = 16'd4;
      @(negedge clk);
      chk("hold_q", 32'(q), 32'h0FFF);
      chk("hold_r", 32'(r), 32'h000F);
      chk("hold_calc", 32'(calculated), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_second_busy", 32'(busy), 32'd1);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
